// File: rtl/agc_downlink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : agc_downlink_pkg
// Purpose  : Shared types and constants for the AGC telemetry downlink
//            transmitter. This includes the word width, the data bits per
//            frame, the FSM state type and the frame-building helper.
// Macro    : DOWNLINK_PARITY_EN. When this macro is defined, an odd-parity
//            bit follows each 16-bit word. This makes the frame 34 data bits
//            long instead of 32.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package agc_downlink_pkg;

  localparam int WORD_W = 16;

`ifdef DOWNLINK_PARITY_EN
  localparam int FRAME_DATA_BITS = 2 * WORD_W + 2;
`else
  localparam int FRAME_DATA_BITS = 2 * WORD_W;
`endif

  // Wide enough for the largest sync count (15) and for the data bit count (34).
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } dl_state_t;

  // Builds the frame so that it goes out MSB first. With parity enabled,
  // each word is followed by its odd-parity bit. That bit is set when the
  // word holds an even number of ones.
  function automatic logic [FRAME_DATA_BITS-1:0] build_frame(
    input logic [WORD_W-1:0] a,
    input logic [WORD_W-1:0] b
  );
`ifdef DOWNLINK_PARITY_EN
    return {a, ~^a, b, ~^b};
`else
    return {a, b};
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/agc_downlink_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : agc_downlink_tx_if
// Purpose  : Bus between the channel-register logic (master) and the
//            downlink transmitter (slave).
// Signals  : word_a/word_b (ch34/ch35 words)
//            load           (start strobe)
//            ready, busy    (status)
//            ser_data, ser_gate (serial line)
//            downrupt       (end-of-frame pulse)
//            overrun        (sticky: a load arrived while not ready)
// Macro    : DOWNLINK_PARITY_EN (no effect on this interface)
// Revision : 1.0  initial release
// ============================================================================
interface agc_downlink_tx_if;
  import agc_downlink_pkg::*;

  logic [WORD_W-1:0] word_a;
  logic [WORD_W-1:0] word_b;
  logic              load;
  logic              ready;
  logic              ser_data;
  logic              ser_gate;
  logic              busy;
  logic              downrupt;
  logic              overrun;

  modport master (
    output word_a, word_b, load,
    input  ready, ser_data, ser_gate, busy, downrupt, overrun
  );

  modport slave (
    input  word_a, word_b, load,
    output ready, ser_data, ser_gate, busy, downrupt, overrun
  );

endinterface
`default_nettype wire

// File: rtl/downlink_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : downlink_tick_gen
// Purpose  : Generates the bit-period timebase for the downlink
//            transmitter. bit_end is high on the last cycle of every
//            TICK_DIV-cycle bit period.
// Ports    : clk     in  system clock
//            rst     in  synchronous active-high reset
//            restart in  restarts the period, so that the next cycle is
//                        the first cycle of a bit period
//            bit_end out high on the last cycle of each bit period
// Macro    : DOWNLINK_PARITY_EN (not used here)
// Revision : 1.0  initial release
// ============================================================================
module downlink_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // When TICK_DIV=1, the counter stays at 0, so every cycle ends a bit period.
  assign bit_end = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/agc_downlink_tx.sv
`default_nettype none
// ============================================================================
// Module   : agc_downlink_tx
// Purpose  : Transmit end of the AGC telemetry downlink.
//            - Captures the ch34/ch35 words on an accepted load.
//            - Sends SYNC_BITS sync bits (data=1, gate=0).
//            - Shifts out the frame MSB first with gate=1.
//            - Pulses downrupt for one cycle at the end of the frame.
// Ports    : clk            in  system clock
//            rst            in  synchronous active-high reset
//            bus (slave)        agc_downlink_tx_if
//              word_a/word_b  in  words sampled on an accepted load
//              load           in  start strobe, accepted only when ready=1
//              ready          out high in IDLE
//              ser_data       out serial data line (registered)
//              ser_gate       out high for data/parity bits (registered)
//              busy           out frame in progress
//              downrupt       out one-cycle end-of-frame pulse
//              overrun        out sticky: load seen while ready=0
// Macro    : DOWNLINK_PARITY_EN adds an odd-parity bit after each word
//            (34 data bits per frame).
// Revision : 1.0  initial release
// ============================================================================
module agc_downlink_tx
  import agc_downlink_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int SYNC_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  agc_downlink_tx_if.slave bus
);

  localparam logic [CNT_W-1:0] C_SYNC_LAST = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(FRAME_DATA_BITS - 1);

  dl_state_t                  r_state;
  logic [FRAME_DATA_BITS-1:0] r_shreg;
  logic [CNT_W-1:0]           r_bit_cnt;
  logic                       r_ready;
  logic                       r_busy;
  logic                       r_ser_data;
  logic                       r_ser_gate;
  logic                       r_downrupt;
  logic                       r_overrun;

  logic                       w_accept;
  logic                       w_bit_end;

  // r_ready is high only in IDLE. This includes the downrupt cycle, so a load
  // in that cycle starts the next frame with no idle bit period.
  assign w_accept = bus.load & r_ready;

  downlink_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (w_accept),
    .bit_end (w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_ser_data <= 1'b0;
      r_ser_gate <= 1'b0;
      r_downrupt <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_downrupt <= 1'b0;
      if (bus.load && !r_ready) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg    <= build_frame(bus.word_a, bus.word_b);
            r_bit_cnt  <= '0;
            r_state    <= SYNC;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_ser_data <= 1'b1;
            r_ser_gate <= 1'b0;
          end
        end

        SYNC: begin
          if (w_bit_end) begin
            if (r_bit_cnt == C_SYNC_LAST) begin
              // The first data bit goes onto the line as the last sync period closes.
              r_state    <= SHIFT;
              r_bit_cnt  <= '0;
              r_ser_data <= r_shreg[FRAME_DATA_BITS-1];
              r_ser_gate <= 1'b1;
              r_shreg    <= {r_shreg[FRAME_DATA_BITS-2:0], 1'b0};
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end

        SHIFT: begin
          if (w_bit_end) begin
            if (r_bit_cnt == C_DATA_LAST) begin
              r_state    <= IDLE;
              r_ser_data <= 1'b0;
              r_ser_gate <= 1'b0;
              r_busy     <= 1'b0;
              r_ready    <= 1'b1;
              r_downrupt <= 1'b1;
            end else begin
              r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
              r_ser_data <= r_shreg[FRAME_DATA_BITS-1];
              r_shreg    <= {r_shreg[FRAME_DATA_BITS-2:0], 1'b0};
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.ser_data = r_ser_data;
  assign bus.ser_gate = r_ser_gate;
  assign bus.downrupt = r_downrupt;
  assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_agc_downlink_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_agc_downlink_tx
// Purpose  : Self-checking bench for agc_downlink_tx.
//            - DUT 0 uses TICK_DIV=4, SYNC_BITS=3.
//            - DUT 1 uses TICK_DIV=1, SYNC_BITS=1.
//            The expected serial waveform is derived per cycle from the
//            frame timing rules and a list of the bits in transmit order.
// Macro    : DOWNLINK_PARITY_EN (the reference adds parity bits and the
//            parity scenario runs)
// Revision : 1.0  initial release
// ============================================================================
module tb_agc_downlink_tx;

  localparam int TD0 = 4;
  localparam int SB0 = 3;
  localparam int TD1 = 1;
  localparam int SB1 = 1;
`ifdef DOWNLINK_PARITY_EN
  localparam int FB = 34;
`else
  localparam int FB = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load_drv;
  logic [15:0] wa_drv;
  logic [15:0] wb_drv;
  int          sel;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_ovr [2];
  bit ref_bits [$];

  agc_downlink_tx_if if0 ();
  agc_downlink_tx_if if1 ();

  assign if0.word_a = wa_drv;
  assign if0.word_b = wb_drv;
  assign if0.load   = load_drv & (sel == 0);
  assign if1.word_a = wa_drv;
  assign if1.word_b = wb_drv;
  assign if1.load   = load_drv & (sel == 1);

  agc_downlink_tx #(.TICK_DIV(TD0), .SYNC_BITS(SB0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  agc_downlink_tx #(.TICK_DIV(TD1), .SYNC_BITS(SB1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // Observed vector order: {ser_data, ser_gate, busy, ready, downrupt, overrun}
  logic [5:0] obs0, obs1, obs;
  assign obs0 = {if0.ser_data, if0.ser_gate, if0.busy, if0.ready, if0.downrupt, if0.overrun};
  assign obs1 = {if1.ser_data, if1.ser_gate, if1.busy, if1.ready, if1.downrupt, if1.overrun};
  assign obs  = (sel == 1) ? obs1 : obs0;

  // Transmit order: word_a MSB..LSB, [pa], word_b MSB..LSB, [pb].
  // Odd parity means the parity bit is 1 when the word holds an even number of ones.
  function automatic void build_ref(input logic [15:0] wa, input logic [15:0] wb);
    int ones_a, ones_b;
    ones_a = 0;
    ones_b = 0;
    ref_bits.delete();
    for (int i = 15; i >= 0; i--) begin
      ref_bits.push_back(wa[i]);
      ones_a += int'(wa[i]);
    end
`ifdef DOWNLINK_PARITY_EN
    ref_bits.push_back((ones_a % 2) == 0);
`endif
    for (int i = 15; i >= 0; i--) begin
      ref_bits.push_back(wb[i]);
      ones_b += int'(wb[i]);
    end
`ifdef DOWNLINK_PARITY_EN
    ref_bits.push_back((ones_b % 2) == 0);
`endif
  endfunction

  // Expected outputs k cycles after the accepting edge (k=1 is the first sync cycle).
  function automatic logic [5:0] expect_at(input int k, input int td, input int sb, input bit ovr);
    int sync_end, data_end;
    sync_end = sb * td;
    data_end = (sb + FB) * td;
    if (k <= sync_end)      return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ovr};
    if (k <= data_end)      return {ref_bits[(k - sync_end - 1) / td], 1'b1, 1'b1, 1'b0, 1'b0, ovr};
    if (k == data_end + 1)  return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ovr};
    return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ovr};
  endfunction

  task automatic start_frame(input logic [15:0] wa, input logic [15:0] wb);
    @(negedge clk);
    load_drv = 1'b1;
    wa_drv   = wa;
    wb_drv   = wb;
    @(posedge clk);
    #1;
    load_drv = 1'b0;
    wa_drv   = 16'($urandom);
    wb_drv   = 16'($urandom);
  endtask

  // Call this right after the accepting edge.
  // - ovr_k: injects a stray load in cycle ovr_k (0 = none).
  // - rst_k: asserts reset in cycle rst_k (0 = none).
  // - chain: issues the next load (na/nb) in the downrupt cycle.
  task automatic watch_frame(input logic [15:0] wa, input logic [15:0] wb, input int ovr_k,
                             input int rst_k, input bit chain, input logic [15:0] na,
                             input logic [15:0] nb, input string tag);
    int td, sb, dr;
    logic [5:0] exp;
    td = (sel == 1) ? TD1 : TD0;
    sb = (sel == 1) ? SB1 : SB0;
    dr = (sb + FB) * td + 1;
    build_ref(wa, wb);
    for (int k = 1; k <= dr + 1; k++) begin
      @(negedge clk);
      load_drv = 1'b0;
      exp = expect_at(k, td, sb, exp_ovr[sel]);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s cycle %0d: {data,gate,busy,ready,downrupt,overrun} got %b want %b", tag, k, obs, exp);
      end
      if (k == ovr_k) begin
        load_drv     = 1'b1;
        wa_drv       = 16'($urandom);
        wb_drv       = 16'($urandom);
        exp_ovr[sel] = 1'b1;
      end
      if (k == rst_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        exp_ovr[0] = 1'b0;
        exp_ovr[1] = 1'b0;
        for (int j = 0; j < 2 * (sb + FB) * td; j++) begin
          n_cmp++;
          if (obs !== 6'b000100) begin
            n_bad++;
            $display("FAIL %s after-reset cycle %0d: got %b want %b", tag, j, obs, 6'b000100);
          end
          @(negedge clk);
        end
        return;
      end
      if (chain && k == dr) begin
        load_drv = 1'b1;
        wa_drv   = na;
        wb_drv   = nb;
        @(posedge clk);
        #1;
        load_drv = 1'b0;
        wa_drv   = 16'($urandom);
        wb_drv   = 16'($urandom);
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs0 !== 6'b000100) begin n_bad++; $display("FAIL reset dut0: got %b want %b", obs0, 6'b000100); end
    n_cmp++;
    if (obs1 !== 6'b000100) begin n_bad++; $display("FAIL reset dut1: got %b want %b", obs1, 6'b000100); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs0 !== 6'b000100) begin n_bad++; $display("FAIL idle dut0: got %b want %b", obs0, 6'b000100); end
    n_cmp++;
    if (obs1 !== 6'b000100) begin n_bad++; $display("FAIL idle dut1: got %b want %b", obs1, 6'b000100); end
  endtask

  task automatic test_basic();
    sel = 0;
    start_frame(16'hA5F0, 16'h0001);
    watch_frame(16'hA5F0, 16'h0001, 0, 0, 1'b0, 16'h0, 16'h0, "basic");
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    sel = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    start_frame(a, b);
    watch_frame(a, b, 0, 0, 1'b1, 16'hFFFF, 16'h0000, "b2b_first");
    watch_frame(16'hFFFF, 16'h0000, 0, 0, 1'b0, 16'h0, 16'h0, "b2b_second");
  endtask

  task automatic test_overrun();
    logic [15:0] a, b;
    sel = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    start_frame(a, b);
    watch_frame(a, b, SB0 * TD0 + 5 * TD0 + 2, 0, 1'b0, 16'h0, 16'h0, "overrun_frame");
    // overrun must survive later frames
    start_frame(b, a);
    watch_frame(b, a, 0, 0, 1'b0, 16'h0, 16'h0, "overrun_sticky");
  endtask

  task automatic test_reset_midframe();
    logic [15:0] a, b;
    sel = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    start_frame(a, b);
    watch_frame(a, b, 0, SB0 * TD0 + 9 * TD0 + 1, 1'b0, 16'h0, 16'h0, "rst_mid");
  endtask

  task automatic test_parity();
`ifdef DOWNLINK_PARITY_EN
    sel = 0;
    start_frame(16'h0003, 16'h0007);
    watch_frame(16'h0003, 16'h0007, 0, 0, 1'b0, 16'h0, 16'h0, "parity");
`endif
  endtask

  task automatic test_tick1();
    logic [15:0] a, b;
    sel = 1;
    a = 16'($urandom);
    b = 16'($urandom);
    start_frame(a, b);
    watch_frame(a, b, 0, 0, 1'b1, b, a, "tick1_first");
    watch_frame(b, a, 0, 0, 1'b0, 16'h0, 16'h0, "tick1_second");
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int n = 0; n < 6; n++) begin
      sel = int'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_frame(a, b);
      watch_frame(a, b, 0, 0, 1'b0, 16'h0, 16'h0, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_drv   = 1'b0;
    wa_drv     = 16'h0;
    wb_drv     = 16'h0;
    sel        = 0;
    exp_ovr[0] = 1'b0;
    exp_ovr[1] = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_tick1();
    test_parity();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
